imm_decode_sequencer: RTL

Decode-stage sequencer that accepts fetched instructions over a valid/ready handshake. It classifies each opcode into the team's immediate-type encoding and forms the 32-bit immediate and the PC-relative branch/jump target. It buffers decoded records in a small in-order queue and issues them to the execute stage over a second valid/ready handshake. It sits between the IF and EX pipeline registers and owns decode-side backpressure and flush.

---
 rtl/imm_decode_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/imm_decode_sequencer.sv
// Decode-stage sequencer: forms RV32 immediates and branch/jump targets at enqueue,
// then issues the decoded records in order through a DEPTH-entry queue with flush.
module imm_decode_sequencer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_imm,
  output logic [2:0]       out_imm_type,
  output logic [31:0]      out_target,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  imm_type;
    logic [31:0] target;
    logic        illegal;
  } rec_t;

  logic [31:0]      dec_imm;
  logic [2:0]       dec_type;
  logic             dec_illegal;
  logic [31:0]      dec_target;
  rec_t             rec_in;
  rec_t             head;
  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;
  logic [CNT_W-1:0] issued_reg;
  logic             push;
  logic             pop;

  always_comb begin
    dec_imm     = '0;
    dec_type    = TYPE_R;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_type = TYPE_I;
        dec_imm  = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_type = TYPE_S;
        dec_imm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_type = TYPE_B;
        dec_imm  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_type = TYPE_U;
        dec_imm  = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_type = TYPE_J;
        dec_imm  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_type = TYPE_R;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Only PC-relative control transfers carry a target; jalr is register-relative.
  assign dec_target = ((dec_type == TYPE_B) || (dec_type == TYPE_J)) ? (in_pc + dec_imm) : '0;

  always_comb begin
    rec_in          = '0;
    rec_in.instr    = in_instr;
    rec_in.pc       = in_pc;
    rec_in.imm      = dec_imm;
    rec_in.imm_type = dec_type;
    rec_in.target   = dec_target;
    rec_in.illegal  = dec_illegal;
  end

  assign in_ready  = (occ_reg != FULL_OCC);
  assign out_valid = (occ_reg != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= rec_in;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      issued_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        issued_reg <= issued_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Fields read as zero whenever the queue is empty, so reset clears them at once.
  assign head         = mem[rd_ptr_reg];
  assign out_instr    = out_valid ? head.instr    : '0;
  assign out_pc       = out_valid ? head.pc       : '0;
  assign out_imm      = out_valid ? head.imm      : '0;
  assign out_imm_type = out_valid ? head.imm_type : '0;
  assign out_target   = out_valid ? head.target   : '0;
  assign out_illegal  = out_valid ? head.illegal  : 1'b0;
  assign issued_cnt   = issued_reg;

endmodule
